// File: rtl/agc_mem_pkg.sv
// agc_mem_pkg: shared definitions for the banked erasable memory.
//   - state_t        : controller states (INIT clears the array, IDLE serves requests)
//   - ERASABLE_LSB   : lowest address bit of the region field; field == 0 means erasable
//   - SWITCHED_BANK  : value of addr[9:8] that selects the EBANK-switched window
//   - ZERO_ADDR_DEF / EBANK_ADDR_DEF : default special-location addresses
//   - phys_addr()    : CPU erasable address + bank register -> physical word index
package agc_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int          ERASABLE_LSB   = 10;
  localparam logic [1:0]  SWITCHED_BANK  = 2'b11;
  localparam int          ZERO_ADDR_DEF  = 7;
  localparam int          EBANK_ADDR_DEF = 3;

  // Widest physical index phys_addr() can produce (8-bit bank + 8-bit offset).
  localparam int          PHYS_MAX_W     = 16;

  // The top 256-word window of the erasable space is banked; the three
  // lower windows map straight through to physical words 0..767.
  function automatic logic [PHYS_MAX_W-1:0] phys_addr(input logic [9:0] addr,
                                                      input logic [7:0] bank);
    if (addr[9:8] == SWITCHED_BANK) begin
      return {bank, addr[7:0]};
    end
    return {6'b0, addr};
  endfunction

endpackage

// File: rtl/erasable_ram.sv
// erasable_ram: single-port word array, synchronous write, registered read.
// Ports:
//   clk    in   clock
//   we     in   write enable for this cycle
//   addr   in   [DEPTH_W] word index (read and write share it)
//   wdata  in   [WIDTH] write word
//   q      out  [WIDTH] word read at the previous edge (read-before-write)
// No reset: contents are cleared by the controller's INIT sweep instead.
module erasable_ram #(
  parameter int DEPTH_W = 11,
  parameter int WIDTH   = 15
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/erasable_memory_banked.sv
// erasable_memory_banked: request/response front end to banked erasable storage.
// Ports:
//   clk, reset (async, active high)
//   req_valid/req_ready/req_we/req_addr/req_data : request port, one per cycle
//   par_inject : (ERASABLE_PARITY_EN only) flip stored parity on an accepted write
//   rsp_valid/rsp_data/rsp_err : response, one cycle after acceptance
//   ebank      : current bank register (memory-mapped at EBANK_ADDR)
//   err_count  : saturating count of rejected requests / parity failures
// Optional build macro: ERASABLE_PARITY_EN adds an odd-parity bit per word.
module erasable_memory_banked
  import agc_mem_pkg::*;
#(
  parameter int DATA_W     = 15,
  parameter int ADDR_W     = 12,
  parameter int EBANK_W    = 3,
  parameter int ZERO_ADDR  = ZERO_ADDR_DEF,
  parameter int EBANK_ADDR = EBANK_ADDR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
`ifdef ERASABLE_PARITY_EN
  input  logic               par_inject,
`endif
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [EBANK_W-1:0] ebank,
  output logic [7:0]         err_count
);

  localparam int PHYS_W = EBANK_W + 8;
`ifdef ERASABLE_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_t              state_reg, state_next;
  logic [PHYS_W-1:0]   init_cnt_reg;
  logic [EBANK_W-1:0]  ebank_reg;
  logic [7:0]          err_count_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  // Response carries array data (normal read); otherwise rsp_data is forced 0.
  logic                pass_reg;

  logic                accept;
  logic                is_erasable;
  logic                is_zero;
  logic                is_ebank;
  logic [PHYS_MAX_W-1:0] phys_full;
  logic [PHYS_W-1:0]   phys;
  logic                phys_unused;

  logic                ram_we;
  logic [PHYS_W-1:0]   ram_addr;
  logic [RAM_W-1:0]    ram_wdata;
  logic [RAM_W-1:0]    ram_q;
  logic                par_err;
  logic [8:0]          err_sum;

  // ---------------- decode ----------------
  assign accept      = req_valid & req_ready;
  assign is_erasable = (req_addr[ADDR_W-1:ERASABLE_LSB] == '0);
  assign is_zero     = (req_addr == ADDR_W'(ZERO_ADDR));
  assign is_ebank    = (req_addr == ADDR_W'(EBANK_ADDR));
  assign phys_full   = phys_addr(req_addr[9:0], 8'(ebank_reg));
  assign phys        = phys_full[PHYS_W-1:0];
  assign phys_unused = ^phys_full[PHYS_MAX_W-1:PHYS_W];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    case (state_reg)
      INIT: begin
        if (init_cnt_reg == '1) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  // ---------------- array port ----------------
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = phys;
    ram_wdata = '0;
    if (state_reg == INIT) begin
      ram_we   = 1'b1;
      ram_addr = init_cnt_reg;
`ifdef ERASABLE_PARITY_EN
      ram_wdata = {1'b1, {DATA_W{1'b0}}};  // odd parity of an all-zero word
`endif
    end else if (accept && is_erasable && req_we && !is_zero) begin
      ram_we = 1'b1;
`ifdef ERASABLE_PARITY_EN
      ram_wdata = {~(^req_data) ^ par_inject, req_data};
`else
      ram_wdata = req_data;
`endif
    end
  end

  erasable_ram #(
    .DEPTH_W (PHYS_W),
    .WIDTH   (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // ---------------- sequential state ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt_reg  <= '0;
      ebank_reg     <= '0;
      err_count_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      pass_reg      <= 1'b0;
    end else begin
      if (state_reg == INIT) begin
        init_cnt_reg <= init_cnt_reg + 1'b1;
      end
      if (accept && is_erasable && req_we && is_ebank) begin
        ebank_reg <= req_data[EBANK_W+7:8];
      end
      rsp_valid_reg <= accept;
      rsp_err_reg   <= accept & ~is_erasable;
      pass_reg      <= accept & is_erasable & ~req_we & ~is_zero;
      err_count_reg <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
    end
  end

  // Parity is only known once the word is out of the array, so a parity
  // failure is flagged with the response and counted on the following edge,
  // while a fixed-region rejection is counted at the acceptance edge. Both
  // can land on the same edge, hence the two-term sum.
`ifdef ERASABLE_PARITY_EN
  assign par_err = pass_reg & ~(^ram_q);
`else
  assign par_err = 1'b0;
`endif
  assign err_sum = {1'b0, err_count_reg} + 9'(accept & ~is_erasable) + 9'(par_err);

  // ---------------- outputs ----------------
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg | par_err;
  assign rsp_data  = pass_reg ? ram_q[DATA_W-1:0] : '0;
  assign ebank     = ebank_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_erasable_memory_banked.sv
// tb_erasable_memory_banked: directed + randomized checks of erasable_memory_banked
// against a word-array reference model. Define ERASABLE_PARITY_EN for the
// parity build as well.
module tb_erasable_memory_banked;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [14:0] req_data = '0;
  logic        par_inject = 1'b0;
  logic        rsp_valid;
  logic [14:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  ebank;
  logic [7:0]  err_count;

  int total = 0;
  int passed = 0;

  // reference model state
  int m_mem [2048];
  bit m_bad [2048];
  int m_ebank;
  int m_err;

  always #5 clk = ~clk;

  erasable_memory_banked dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_data   (req_data),
`ifdef ERASABLE_PARITY_EN
    .par_inject (par_inject),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ebank      (ebank),
    .err_count  (err_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2048; i++) begin
      m_mem[i] = 0;
      m_bad[i] = 1'b0;
    end
    m_ebank = 0;
    m_err   = 0;
  endtask

  // Behavioural rules: fixed region rejects, low 768 words are direct,
  // 0x300..0x3FF goes through the bank, 7 reads zero and ignores writes,
  // 3 is both a word and the bank register.
  task automatic model_req(input bit we, input int addr, input int data, input bit inj,
                           output int exp_data, output bit exp_err, output bit par_fail);
    int phys;
    exp_data = 0;
    exp_err  = 1'b0;
    par_fail = 1'b0;
    if (addr >= 1024) begin
      exp_err = 1'b1;
      if (m_err < 255) m_err++;
    end else begin
      if (addr >= 768) phys = m_ebank * 256 + (addr % 256);
      else phys = addr;
      if (we) begin
        if (addr != 7) begin
          m_mem[phys] = data;
          m_bad[phys] = inj;
          if (addr == 3) m_ebank = (data / 256) % 8;
        end
      end else if (addr != 7) begin
        exp_data = m_mem[phys];
        exp_err  = m_bad[phys];
        par_fail = m_bad[phys];
      end
    end
  endtask

  // Called #1 after an edge; presents one request, checks its response
  // #1 after the accepting edge. Consecutive calls are back-to-back.
  task automatic issue(input bit we, input int addr, input int data, input bit inj);
    int ed;
    bit ee;
    bit pf;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = 12'(addr);
    req_data   = 15'(data);
    par_inject = inj;
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    model_req(we, addr, data, inj, ed, ee, pf);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(ed));
    check("rsp_err", 32'(rsp_err), 32'(ee));
    check("ebank", 32'(ebank), 32'(m_ebank));
    check("err_count", 32'(err_count), 32'(m_err));
    $display("%s addr=%03h data=%04h -> rsp_data=%04h err=%0d ebank=%0d err_count=%0d",
             we ? "WR" : "RD", addr, data, rsp_data, rsp_err, ebank, err_count);
    if (pf && m_err < 255) m_err++;
    req_valid  = 1'b0;
    par_inject = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_data", 32'(rsp_data), 32'd0);
    check("idle_err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic wait_ready(input string tag);
    int cycles = 0;
    while (req_ready !== 1'b1 && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check(tag, 32'(cycles), 32'd2048);
    $display("INIT done after %0d cycles", cycles);
  endtask

  initial begin
    int a;
    int d;
    int kind;

    model_clear();
    // ---------- reset values ----------
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ebank", 32'(ebank), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("init_cycles");

    // ---------- directed ----------
    issue(0, 12'h010, 0, 0);
    check("dir_init_read", 32'(rsp_data), 32'h0);
    issue(1, 12'h010, 15'h1234, 0);
    issue(0, 12'h010, 0, 0);
    check("dir_raw_read", 32'(rsp_data), 32'h1234);
    idle();
    issue(1, 12'h003, 15'h0200, 0);
    check("dir_ebank2", 32'(ebank), 32'd2);
    issue(1, 12'h305, 15'h7FFF, 0);
    issue(1, 12'h003, 15'h0000, 0);
    issue(0, 12'h305, 0, 0);
    check("dir_bank0_read", 32'(rsp_data), 32'h0);
    issue(1, 12'h003, 15'h0200, 0);
    issue(0, 12'h305, 0, 0);
    check("dir_bank2_read", 32'(rsp_data), 32'h7FFF);
    issue(0, 12'h003, 0, 0);
    check("dir_ebank_word", 32'(rsp_data), 32'h0200);
    issue(1, 12'h007, 15'h5555, 0);
    issue(0, 12'h007, 0, 0);
    check("dir_zero_read", 32'(rsp_data), 32'h0);
    check("dir_zero_errcnt", 32'(err_count), 32'd0);
    issue(1, 12'h400, 15'h1111, 0);
    issue(0, 12'hC00, 0, 0);
    check("dir_fixed_err", 32'(rsp_err), 32'd1);
    check("dir_fixed_errcnt", 32'(err_count), 32'd2);
    idle();

    // ---------- randomized traffic ----------
    for (int i = 0; i < 500; i++) begin
      kind = $urandom_range(0, 9);
      d = $urandom_range(0, 32767);
      case (kind)
        0, 1, 2: a = 12'h300 + $urandom_range(0, 255);
        3, 4, 5: a = $urandom_range(0, 1023);
        6:       a = 3;
        7:       a = 7;
        8:       a = $urandom_range(1024, 4095);
        default: a = 12'h010 + $urandom_range(0, 3);
      endcase
      issue(1'($urandom_range(0, 1)), a, d, 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

`ifdef ERASABLE_PARITY_EN
    // ---------- parity ----------
    issue(1, 12'h020, 15'h0001, 1);
    issue(0, 12'h020, 0, 0);
    check("par_err", 32'(rsp_err), 32'd1);
    check("par_data", 32'(rsp_data), 32'h0001);
    idle();
    issue(1, 12'h020, 15'h0001, 0);
    issue(0, 12'h020, 0, 0);
    check("par_clean", 32'(rsp_err), 32'd0);
    idle();
`endif

    // ---------- saturation ----------
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(1024, 4095), $urandom_range(0, 32767), 0);
    end
    idle();
    check("err_saturated", 32'(err_count), 32'd255);

    // ---------- reset mid-traffic ----------
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'h010;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    // ---------- reset mid-INIT ----------
    repeat (100) @(posedge clk);
    #1;
    check("mid_init_not_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_init_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("reinit_cycles");
    issue(0, 12'h010, 0, 0);
    check("after_reinit_read", 32'(rsp_data), 32'h0);
    issue(0, 12'h305, 0, 0);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
